// File: rtl/layer_stream_host_if.sv
// Streaming link between the host and one layer instance; pure wiring, no latency.
// master = host side: drives words toward the layer and accepts its results.
// Backpressure: m_ready stalls host->layer words, s_ready stalls layer->host words.
// Signals: m_valid/m_ready/data_out (host->layer), s_valid/s_ready/data_in (layer->host).
interface layer_stream_host_if #(
  parameter int WIDTH = 8
);
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] data_out;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] data_in;

  modport master (
    output m_valid, input  m_ready, output data_out,
    input  s_valid, output s_ready, input  data_in
  );

  modport slave (
    input  m_valid, output m_ready, input  data_out,
    output s_valid, input  s_ready, output data_in
  );
endinterface

// File: rtl/layer_stream_host.sv
// Host for one streaming layer: streams a loaded TX buffer out, captures results into an RX buffer.
// Latency: first word offered the cycle after start; rd_data is one registered cycle behind rd_addr.
// Backpressure: TX word held until m_ready; RX accepted only while s_ready (no storage otherwise).
// Ports: clk/reset (async, active-high); ld_en/ld_addr/ld_data loader; start/num_vec run control;
//   lnk (master modport) layer stream; rd_addr/rd_data result read; busy/done/cycles status.
// Optional build macro HOST_STALL_INJECT_EN: LFSR-driven bubbles on s_ready and m_valid rises.
module layer_stream_host #(
  parameter int WIDTH = 8,
  parameter int M     = 8,
  parameter int N     = 8,
  parameter int VECS  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ld_en,
  input  logic [$clog2(M*VECS)-1:0]   ld_addr,
  input  logic [WIDTH-1:0]            ld_data,
  input  logic                        start,
  input  logic [$clog2(VECS):0]       num_vec,
  layer_stream_host_if.master         lnk,
  input  logic [$clog2(N*VECS)-1:0]   rd_addr,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 cycles
);
  localparam int TX_SZ = M * VECS;
  localparam int RX_SZ = N * VECS;
  localparam int TXAW  = $clog2(TX_SZ);
  localparam int RXAW  = $clog2(RX_SZ);
  localparam int NVW   = $clog2(VECS) + 1;
  // counters must reach the full buffer size, hence the +1
  localparam int CW    = $clog2(((TX_SZ > RX_SZ) ? TX_SZ : RX_SZ) + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [NVW-1:0]   r_nv, w_nv_nxt;
  logic [CW-1:0]    r_tx_cnt, r_rx_cnt, w_tx_cnt_nxt, w_rx_cnt_nxt;
  logic [CW-1:0]    w_tx_tot, w_rx_tot, w_tx_tot_nxt, w_rx_tot_nxt;
  logic             r_m_valid, r_s_ready, w_m_valid_nxt, w_s_ready_nxt;
  logic             w_tx_fire, w_rx_fire;
  logic             r_busy, r_done;
  logic [15:0]      r_cycles;
  logic [WIDTH-1:0] r_rd_data;
  logic [WIDTH-1:0] r_txbuf [TX_SZ];
  logic [WIDTH-1:0] r_rxbuf [RX_SZ];
  logic             w_rise_ok, w_rx_ok;

`ifdef HOST_STALL_INJECT_EN
  // Fibonacci LFSR x^8+x^6+x^5+x^4+1. Valid/ready are registered, so they are
  // gated with the value the LFSR will hold in the cycle they become visible.
  logic [7:0] r_lfsr, w_lfsr_nxt;
  assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= 8'hA5;
    else       r_lfsr <= w_lfsr_nxt;
  end
  assign w_rise_ok = ~w_lfsr_nxt[1];
  assign w_rx_ok   = ~w_lfsr_nxt[0];
`else
  assign w_rise_ok = 1'b1;
  assign w_rx_ok   = 1'b1;
`endif

  assign w_tx_fire = r_m_valid & lnk.m_ready;
  assign w_rx_fire = r_s_ready & lnk.s_valid;
  assign w_tx_tot  = CW'(M) * CW'(r_nv);
  assign w_rx_tot  = CW'(N) * CW'(r_nv);

  always_comb begin
    w_state_nxt  = r_state;
    w_nv_nxt     = r_nv;
    w_tx_cnt_nxt = r_tx_cnt + CW'(w_tx_fire);
    w_rx_cnt_nxt = r_rx_cnt + CW'(w_rx_fire);
    case (r_state)
      // completion looks at post-transfer counts so the final transfers and
      // the DONE transition share one edge
      S_RUN: if (w_tx_cnt_nxt == w_tx_tot && w_rx_cnt_nxt == w_rx_tot) w_state_nxt = S_DONE;
      default: begin
        if (start) begin
          w_state_nxt  = S_RUN;
          w_nv_nxt     = (num_vec > NVW'(VECS)) ? NVW'(VECS) : num_vec;
          w_tx_cnt_nxt = '0;
          w_rx_cnt_nxt = '0;
        end
      end
    endcase
    w_tx_tot_nxt  = CW'(M) * CW'(w_nv_nxt);
    w_rx_tot_nxt  = CW'(N) * CW'(w_nv_nxt);
    // a valid already high stays high; only a fresh rise waits for a stall-free slot
    w_m_valid_nxt = (w_state_nxt == S_RUN) && (w_tx_cnt_nxt < w_tx_tot_nxt) && (r_m_valid || w_rise_ok);
    w_s_ready_nxt = (w_state_nxt == S_RUN) && (w_rx_cnt_nxt < w_rx_tot_nxt) && w_rx_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_nv      <= '0;
      r_tx_cnt  <= '0;
      r_rx_cnt  <= '0;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cycles  <= '0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_nv      <= w_nv_nxt;
      r_tx_cnt  <= w_tx_cnt_nxt;
      r_rx_cnt  <= w_rx_cnt_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_s_ready <= w_s_ready_nxt;
      r_busy    <= (w_state_nxt == S_RUN);
      r_done    <= (w_state_nxt == S_DONE);
      if (r_state == S_RUN) begin
        if (r_cycles != 16'hFFFF) r_cycles <= r_cycles + 16'd1;
      end else if (start) begin
        r_cycles <= '0;
      end
      r_rd_data <= (int'(rd_addr) < RX_SZ) ? r_rxbuf[rd_addr] : '0;
    end
  end

  // buffers intentionally carry no reset
  always_ff @(posedge clk) begin
    if (ld_en && r_state != S_RUN && int'(ld_addr) < TX_SZ) r_txbuf[ld_addr] <= ld_data;
    if (w_rx_fire) r_rxbuf[r_rx_cnt[RXAW-1:0]] <= lnk.data_in;
  end

  // tx_cnt only moves on accept, so the offered word is stable while stalled
  assign lnk.data_out = r_m_valid ? r_txbuf[r_tx_cnt[TXAW-1:0]] : '0;
  assign lnk.m_valid  = r_m_valid;
  assign lnk.s_ready  = r_s_ready;
  assign rd_data      = r_rd_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign cycles       = r_cycles;
endmodule

// File: tb/tb_layer_stream_host.sv
// Bench for layer_stream_host: directed runs, a rule-level reference model checked every cycle,
// plus literal expectations for the hand-computed cases.
module tb_layer_stream_host;
  localparam int WIDTH = 8, M = 8, N = 8, VECS = 4;
  localparam int TX_SZ = M * VECS, RX_SZ = N * VECS;

  logic                      clk = 1'b0, reset = 1'b1;
  logic                      ld_en = 1'b0, start = 1'b0;
  logic [$clog2(TX_SZ)-1:0]  ld_addr = '0;
  logic [$clog2(RX_SZ)-1:0]  rd_addr = '0;
  logic [WIDTH-1:0]          ld_data = '0;
  logic [$clog2(VECS):0]     num_vec = '0;
  logic [WIDTH-1:0]          rd_data;
  logic                      busy, done;
  logic [15:0]               cycles;

  layer_stream_host_if #(.WIDTH(WIDTH)) lnk();

  layer_stream_host #(.WIDTH(WIDTH), .M(M), .N(N), .VECS(VECS)) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .num_vec(num_vec), .lnk(lnk), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  // ---------------- reference model (state of the current cycle) ----------------
  int       mst;           // 0 idle, 1 run, 2 done
  int       mtx, mrx, mnv, mcyc;
  bit       mmv, msr;
  int       tx_img [TX_SZ];
  int       rx_img [RX_SZ];
  bit       rx_known [RX_SZ];
  int       exp_rd;
  bit       rd_known;
  logic [7:0] ml;
  int       txq [$];       // words actually accepted by the layer
  int       rxn;           // results actually accepted by the host

  task automatic model_reset();
    mst = 0; mtx = 0; mrx = 0; mnv = 0; mcyc = 0;
    mmv = 0; msr = 0; exp_rd = 0; rd_known = 1; ml = 8'hA5;
  endtask

  task automatic model_step();
    bit txf, rxf, want_tx, want_rx;
    txf = mmv && lnk.m_ready;
    rxf = msr && lnk.s_valid;
    if (int'(rd_addr) < RX_SZ) begin
      exp_rd = rx_img[rd_addr]; rd_known = rx_known[rd_addr];
    end else begin
      exp_rd = 0; rd_known = 1;
    end
    if (txf) mtx++;
    if (rxf) begin rx_img[mrx] = int'(lnk.data_in); rx_known[mrx] = 1; mrx++; end
    if (ld_en && mst != 1 && int'(ld_addr) < TX_SZ) tx_img[ld_addr] = int'(ld_data);
    if (mst == 1) begin
      if (mcyc < 65535) mcyc++;
      if (mtx == M * mnv && mrx == N * mnv) mst = 2;
    end else if (start) begin
      mst = 1; mnv = (int'(num_vec) > VECS) ? VECS : int'(num_vec);
      mtx = 0; mrx = 0; mcyc = 0;
    end
    ml = {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
    want_tx = (mst == 1) && (mtx < M * mnv);
    want_rx = (mst == 1) && (mrx < N * mnv);
`ifdef HOST_STALL_INJECT_EN
    mmv = want_tx && (mmv || !ml[1]);
    msr = want_rx && !ml[0];
`else
    mmv = want_tx;
    msr = want_rx;
`endif
  endtask

  initial begin
    for (int i = 0; i < RX_SZ; i++) rx_known[i] = 0;
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      chk("m_valid",  int'(lnk.m_valid),  int'(mmv));
      chk("data_out", int'(lnk.data_out), mmv ? tx_img[mtx] : 0);
      chk("s_ready",  int'(lnk.s_ready),  int'(msr));
      chk("busy",     int'(busy),         int'(mst == 1));
      chk("done",     int'(done),         int'(mst == 2));
      chk("cycles",   int'(cycles),       mcyc);
      if (rd_known) chk("rd_data", int'(rd_data), exp_rd);
      if (!reset) begin
        if (lnk.m_valid && lnk.m_ready) txq.push_back(int'(lnk.data_out));
        if (lnk.s_valid && lnk.s_ready) rxn++;
        model_step();
      end
    end
  end

  // ---------------- layer-side stimulus ----------------
  int mr_mode = 0;   // 0 low, 1 high, 2 toggle every cycle
  bit rsp_en = 0;
  int rsp_idx = 0;

  initial begin
    lnk.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (mr_mode)
        0:       lnk.m_ready = 1'b0;
        1:       lnk.m_ready = 1'b1;
        default: lnk.m_ready = ~lnk.m_ready;
      endcase
    end
  end

  // returns 10,11,12,... ; a word is held until the host accepts it
  initial begin
    lnk.s_valid = 1'b0;
    lnk.data_in = '0;
    forever begin
      @(negedge clk);
      if (!reset && lnk.s_valid && lnk.s_ready) rsp_idx++;
      @(posedge clk); #1;
      lnk.s_valid = rsp_en;
      lnk.data_in = WIDTH'(10 + rsp_idx);
    end
  end

  // ---------------- directed sequence ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run(input int nv);
    start = 1'b1; num_vec = ($clog2(VECS)+1)'(nv);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    chk(nm, int'(done), 1);
  endtask

  task automatic prep(input int mode, input bit rsp);
    mr_mode = mode; rsp_en = rsp; rsp_idx = 0; txq.delete(); rxn = 0;
  endtask

  initial begin
    int nb, n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",    int'(busy), 0);
    chk("rst_done",    int'(done), 0);
    chk("rst_m_valid", int'(lnk.m_valid), 0);
    chk("rst_cycles",  int'(cycles), 0);
    reset = 1'b0;

    for (int i = 0; i < TX_SZ; i++) begin
      ld_en = 1'b1; ld_addr = ($clog2(TX_SZ))'(i); ld_data = WIDTH'(i + 1);
      tick();
    end
    ld_en = 1'b0;

    // one vector, zero-bubble both directions
    prep(1, 1);
    tick();
    run(1);
    wait_done(40, "t1_done");
    chk("t1_txn", txq.size(), 8);
    for (int k = 0; k < 8 && k < txq.size(); k++) chk("t1_tx_word", txq[k], k + 1);
    chk("t1_rxn", rxn, 8);
    chk("t1_cycles", int'(cycles), 8);
    chk("t1_mvalid_low", int'(lnk.m_valid), 0);
    rsp_en = 0;
    rd_addr = 3; tick();
    chk("t2_rd3", int'(rd_data), 13);

    // m_ready toggling
    prep(2, 1);
    tick();
    run(1);
    wait_done(60, "t3_done");
    chk("t3_txn", txq.size(), 8);
    for (int k = 0; k < 8 && k < txq.size(); k++) chk("t3_tx_word", txq[k], k + 1);
    chk("t3_rxn", rxn, 8);
    rsp_en = 0;
    rd_addr = 7; tick();
    chk("t3_rd7", int'(rd_data), 17);

    // zero vectors: one RUN cycle, no transfers
    prep(1, 0);
    tick();
    run(0);
    nb = 0;
    for (int k = 0; k < 5 && !done; k++) begin
      if (busy) nb++;
      tick();
    end
    chk("t4_busy_cycles", nb, 1);
    chk("t4_done", int'(done), 1);
    chk("t4_no_tx", txq.size(), 0);

    // oversize request clamps to VECS
    prep(1, 1);
    tick();
    run(7);
    wait_done(100, "t4_clamp_done");
    chk("t4_clamp_txn", txq.size(), 32);
    chk("t4_clamp_rxn", rxn, 32);
    if (txq.size() == 32) begin
      chk("t4_tx_8", txq[8], 9);
      chk("t4_tx_31", txq[31], 32);
    end
    chk("t4_cycles", int'(cycles), 32);
    rsp_en = 0;
    rd_addr = 31; tick();
    chk("t4_rd31", int'(rd_data), 41);

    // reset in the middle of a run
    prep(1, 0);
    tick();
    run(1);
    n = 0;
    while (txq.size() < 3 && n < 20) begin tick(); n++; end
    chk("t5_three_tx", txq.size(), 3);
    reset = 1'b1;
    #1;
    chk("t5_rst_m_valid", int'(lnk.m_valid), 0);
    chk("t5_rst_s_ready", int'(lnk.s_ready), 0);
    chk("t5_rst_busy", int'(busy), 0);
    mr_mode = 0;
    tick();
    reset = 1'b0;
    prep(0, 0);
    tick();
    run(1);
    tick();
    chk("t5_busy", int'(busy), 1);
    ld_en = 1'b1; ld_addr = '0; ld_data = WIDTH'(99);
    tick();
    ld_en = 1'b0;
    tick();
    chk("t5_word0_kept", int'(lnk.data_out), 1);
    prep(1, 1);
    wait_done(60, "t5_done");
    chk("t5_txn", txq.size(), 8);
    if (txq.size() > 0) chk("t5_restart_word0", txq[0], 1);

`ifdef HOST_STALL_INJECT_EN
    rsp_en = 0;
    tick();
    prep(1, 1);
    tick();
    run(2);
    wait_done(400, "t6_done");
    chk("t6_txn", txq.size(), 16);
    for (int k = 0; k < 16 && k < txq.size(); k++) chk("t6_tx_word", txq[k], k + 1);
    chk("t6_rxn", rxn, 16);
    chk("t6_cycles_gt16", int'(cycles > 16'd16), 1);
    rsp_en = 0;
    rd_addr = 15; tick();
    chk("t6_rd15", int'(rd_data), 25);
`endif

    rsp_en = 0; mr_mode = 0;
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
